// File: rtl/ip_dest_filter_if.sv
`default_nettype none
// =============================================================================
// Module   : ip_dest_filter_if
// Purpose  : AXI4-Stream bundle (data/strobe/user/last + handshake) for ip_dest_filter.
// Revision : 1.0 - initial release
// =============================================================================
interface ip_dest_filter_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/ip_dest_filter.sv
`default_nettype none
// =============================================================================
// Module   : ip_dest_filter
// Purpose  : IPv4 exception filter; steers exception and CPU traffic via TUSER DST.
// Revision : 1.0 - initial release
// =============================================================================
module ip_dest_filter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24,
    parameter int NUM_ENTRIES          = 32,
    parameter int NUM_PORTS            = 4,
    localparam int ADDR_W              = $clog2(NUM_ENTRIES)
) (
    input  wire logic                          AXI_ACLK,
    input  wire logic                          AXI_RESETN,
    ip_dest_filter_if.slave                    s_axis,
    ip_dest_filter_if.master                   m_axis,
    input  wire logic                          tbl_wr_req,
    input  wire logic [ADDR_W-1:0]             tbl_wr_addr,
    input  wire logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    input  wire logic                          tbl_wr_entry_valid,
    output logic                               tbl_wr_ack,
    input  wire logic                          tbl_rd_req,
    input  wire logic [ADDR_W-1:0]             tbl_rd_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      tbl_rd_data,
    output logic                               tbl_rd_entry_valid,
    output logic                               tbl_rd_ack,
    input  wire logic                          counter_clr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      bad_ttl_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      ver_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      non_ip_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      dest_hit_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      short_count
);
    localparam int          FIFO_DEPTH = 4;
    localparam logic [15:0] C_ETH_IPV4 = 16'h0800;
    localparam int          CNT_TTL    = 0;
    localparam int          CNT_VER    = 1;
    localparam int          CNT_NONIP  = 2;
    localparam int          CNT_HIT    = 3;
    localparam int          CNT_SHORT  = 4;
    localparam int          NUM_CNT    = 5;

    typedef struct packed {
        logic [C_S_AXIS_DATA_WIDTH-1:0]   data;
        logic [C_S_AXIS_DATA_WIDTH/8-1:0] strb;
        logic [C_S_AXIS_TUSER_WIDTH-1:0]  user;
        logic                             last;
    } beat_t;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_WAIT  = 2'd1,
        S_EMIT0 = 2'd2,
        S_BODY  = 2'd3
    } state_t;

    beat_t                             fifo_mem_q [FIFO_DEPTH];
    beat_t                             fifo_mem_d [FIFO_DEPTH];
    logic [1:0]                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]                        count_q, count_d;
    logic                              fifo_empty, nearly_full, fifo_wr, fifo_pop;
    beat_t                             head;

    state_t                            state_q, state_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]  hold_strb_q, hold_strb_d;
    logic                              hold_last_q, hold_last_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   user_q, user_d;
    logic                              m_valid;

    logic [C_S_AXI_DATA_WIDTH-1:0]     tbl_data_q [NUM_ENTRIES];
    logic [C_S_AXI_DATA_WIDTH-1:0]     tbl_data_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]            tbl_valid_q, tbl_valid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                              rd_valid_q, rd_valid_d, rd_ack_q, wr_ack_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]     cnt_q [NUM_CNT];
    logic [C_S_AXI_DATA_WIDTH-1:0]     cnt_d [NUM_CNT];

    logic [C_M_AXIS_TUSER_WIDTH-1:0]   base_user, decided_user;
    logic [2*NUM_PORTS-1:0]            src;
    logic                              src_cpu, src_mac, is_ipv4, tbl_hit, decide_en;
    logic [1:0]                        port;
    logic [31:0]                       dest_ip;
    logic [NUM_CNT-1:0]                flags, cnt_inc;

    // Ingress FIFO: head is visible combinationally (fallthrough)
    assign fifo_empty    = (count_q == 3'd0);
    assign nearly_full   = (count_q >= 3'(FIFO_DEPTH - 1));
    assign s_axis.tready = !nearly_full;
    assign fifo_wr       = s_axis.tvalid && !nearly_full;
    assign head          = fifo_mem_q[rd_ptr_q];

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        if (fifo_wr) begin
            fifo_mem_d[wr_ptr_q] = {s_axis.tdata, s_axis.tstrb, s_axis.tuser, s_axis.tlast};
        end
        wr_ptr_d = wr_ptr_q + {1'b0, fifo_wr};
        rd_ptr_d = rd_ptr_q + {1'b0, fifo_pop};
        count_d  = count_q + {2'b00, fifo_wr} - {2'b00, fifo_pop};
    end

    // Beat 0 sits in the hold register while beat 1 is at the FIFO head
    assign is_ipv4 = (hold_data_q[159:144] == C_ETH_IPV4);
    assign dest_ip = {hold_data_q[15:0], head.data[255:240]};

    always_comb begin
        tbl_hit = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (tbl_valid_q[e] && (tbl_data_q[e] == dest_ip)) tbl_hit = 1'b1;
        end
    end

    always_comb begin
        base_user = (state_q == S_HDR) ? head.user : user_q;
        src       = base_user[SRC_PORT_POS +: 2*NUM_PORTS];
        src_cpu   = 1'b0;
        src_mac   = 1'b0;
        port      = 2'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (src[2*i+1]) begin
                src_cpu = 1'b1;
                port    = 2'(i);
            end else if (src[2*i]) begin
                src_mac = 1'b1;
                port    = 2'(i);
            end
        end
        flags = '0;
        if (!src_cpu && src_mac) begin
            if (state_q == S_HDR) begin
                flags[CNT_SHORT] = head.last;
            end else begin
                flags[CNT_NONIP] = !is_ipv4;
                flags[CNT_VER]   = is_ipv4 && (hold_data_q[143:140] != 4'd4);
                flags[CNT_TTL]   = is_ipv4 && (hold_data_q[79:72] <= 8'd1);
                flags[CNT_HIT]   = is_ipv4 && tbl_hit;
            end
        end
        decided_user = base_user;
        if (src_cpu) begin
            decided_user[DST_PORT_POS +: 8] = 8'b0000_0001 << {port, 1'b0};
        end else if (|flags) begin
            decided_user[DST_PORT_POS +: 8] = 8'b0000_0010 << {port, 1'b0};
        end
        decide_en = !fifo_empty &&
                    (((state_q == S_HDR) && head.last) || (state_q == S_WAIT));
        cnt_inc   = flags & {NUM_CNT{decide_en}};
    end

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_strb_d = hold_strb_q;
        hold_last_d = hold_last_q;
        user_d      = user_q;
        fifo_pop    = 1'b0;
        m_valid     = 1'b0;
        case (state_q)
            S_HDR: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    hold_data_d = head.data;
                    hold_strb_d = head.strb;
                    hold_last_d = head.last;
                    user_d      = head.last ? decided_user : head.user;
                    state_d     = head.last ? S_EMIT0 : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!fifo_empty) begin
                    user_d  = decided_user;
                    state_d = S_EMIT0;
                end
            end
            S_EMIT0: begin
                m_valid = 1'b1;
                if (m_axis.tready) state_d = hold_last_q ? S_HDR : S_BODY;
            end
            S_BODY: begin
                m_valid = !fifo_empty;
                if (m_valid && m_axis.tready) begin
                    fifo_pop = 1'b1;
                    if (head.last) state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = (state_q == S_BODY) ? head.data : hold_data_q;
    assign m_axis.tstrb  = (state_q == S_BODY) ? head.strb : hold_strb_q;
    assign m_axis.tuser  = (state_q == S_BODY) ? head.user : user_q;
    assign m_axis.tlast  = (state_q == S_BODY) ? head.last : hold_last_q;

    // Table and counters; lookups see the pre-write table contents
    always_comb begin
        tbl_data_d  = tbl_data_q;
        tbl_valid_d = tbl_valid_q;
        if (tbl_wr_req) begin
            tbl_data_d[tbl_wr_addr]  = tbl_wr_data;
            tbl_valid_d[tbl_wr_addr] = tbl_wr_entry_valid;
        end
        rd_data_d  = tbl_rd_req ? tbl_data_q[tbl_rd_addr]  : rd_data_q;
        rd_valid_d = tbl_rd_req ? tbl_valid_q[tbl_rd_addr] : rd_valid_q;
        for (int k = 0; k < NUM_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (counter_clr) begin
                cnt_d[k] = '0;
            end else if (cnt_inc[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_HDR;
            hold_data_q <= '0;
            hold_strb_q <= '0;
            hold_last_q <= 1'b0;
            user_q      <= '0;
            tbl_valid_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            for (int e = 0; e < NUM_ENTRIES; e++) tbl_data_q[e] <= '0;
            for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_strb_q <= hold_strb_d;
            hold_last_q <= hold_last_d;
            user_q      <= user_d;
            tbl_valid_q <= tbl_valid_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_ack_q    <= tbl_rd_req;
            wr_ack_q    <= tbl_wr_req;
            tbl_data_q  <= tbl_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tbl_wr_ack         = wr_ack_q;
    assign tbl_rd_ack         = rd_ack_q;
    assign tbl_rd_data        = rd_data_q;
    assign tbl_rd_entry_valid = rd_valid_q;
    assign bad_ttl_count      = cnt_q[CNT_TTL];
    assign ver_count          = cnt_q[CNT_VER];
    assign non_ip_count       = cnt_q[CNT_NONIP];
    assign dest_hit_count     = cnt_q[CNT_HIT];
    assign short_count        = cnt_q[CNT_SHORT];
endmodule
`default_nettype wire

// File: tb/tb_ip_dest_filter.sv
`default_nettype none
// =============================================================================
// Module   : tb_ip_dest_filter
// Purpose  : Scoreboard bench for ip_dest_filter with directed packets.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ip_dest_filter;
    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tbl_wr_req = 1'b0, tbl_wr_entry_valid = 1'b0, tbl_rd_req = 1'b0;
    logic [4:0]  tbl_wr_addr = '0, tbl_rd_addr = '0;
    logic [31:0] tbl_wr_data = '0;
    logic        tbl_wr_ack, tbl_rd_ack, tbl_rd_entry_valid;
    logic [31:0] tbl_rd_data;
    logic        counter_clr = 1'b0;
    logic [31:0] bad_ttl_count, ver_count, non_ip_count, dest_hit_count, short_count;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    logic  saw_full;

    ip_dest_filter_if #(.DATA_W(256), .USER_W(128)) s_if ();
    ip_dest_filter_if #(.DATA_W(256), .USER_W(128)) m_if ();

    ip_dest_filter dut (
        .AXI_ACLK           (clk),
        .AXI_RESETN         (rst_n),
        .s_axis             (s_if),
        .m_axis             (m_if),
        .tbl_wr_req         (tbl_wr_req),
        .tbl_wr_addr        (tbl_wr_addr),
        .tbl_wr_data        (tbl_wr_data),
        .tbl_wr_entry_valid (tbl_wr_entry_valid),
        .tbl_wr_ack         (tbl_wr_ack),
        .tbl_rd_req         (tbl_rd_req),
        .tbl_rd_addr        (tbl_rd_addr),
        .tbl_rd_data        (tbl_rd_data),
        .tbl_rd_entry_valid (tbl_rd_entry_valid),
        .tbl_rd_ack         (tbl_rd_ack),
        .counter_clr        (counter_clr),
        .bad_ttl_count      (bad_ttl_count),
        .ver_count          (ver_count),
        .non_ip_count       (non_ip_count),
        .dest_hit_count     (dest_hit_count),
        .short_count        (short_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Monitor: pops the scoreboard on every output handshake, checks stability under stall
    initial begin : monitor
        beat_t got, exp, prev;
        logic  stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                got = {m_if.tdata, m_if.tstrb, m_if.tuser, m_if.tlast};
                if (stalled) begin
                    tests++;
                    if (!m_if.tvalid || got !== prev) begin
                        fails++;
                        $display("FAIL hold_stable: valid=%b user=%h, required valid=1 user=%h",
                                 m_if.tvalid, got.user, prev.user);
                    end
                end
                if (m_if.tvalid && m_if.tready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat: user=%h last=%b, required no beat",
                                 got.user, got.last);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("FAIL beat: user=%h last=%b strb=%h data=%h, required user=%h last=%b strb=%h data=%h",
                                     got.user, got.last, got.strb, got.data,
                                     exp.user, exp.last, exp.strb, exp.data);
                        end
                    end
                end
                stalled = m_if.tvalid && !m_if.tready;
                prev    = got;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] t, input logic [31:0] v,
                             input logic [31:0] n, input logic [31:0] h, input logic [31:0] s);
        check({tag, " bad_ttl_count"},  bad_ttl_count,  t);
        check({tag, " ver_count"},      ver_count,      v);
        check({tag, " non_ip_count"},   non_ip_count,   n);
        check({tag, " dest_hit_count"}, dest_hit_count, h);
        check({tag, " short_count"},    short_count,    s);
    endtask

    function automatic beat_t mk_beat(input logic [7:0] id, input int k, input logic [7:0] src,
                                      input logic [15:0] etype, input logic [3:0] ver,
                                      input logic [7:0] ttl, input logic [31:0] dip, input int nbeats);
        beat_t b;
        b.data = {8{id, 8'(k), 16'hC35A}};
        if (k == 0) begin
            b.data[159:144] = etype;
            b.data[143:140] = ver;
            b.data[79:72]   = ttl;
            b.data[15:0]    = dip[31:16];
        end
        if (k == 1) b.data[255:240] = dip[15:0];
        b.strb = (k == nbeats - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        b.user = {96'h0123_4567_89AB_CDEF_F00D_CAFE, 8'h04, src, id, 8'(k)};
        b.last = (k == nbeats - 1);
        return b;
    endfunction

    task automatic drive_beat(input beat_t b);
        bit done;
        done        = 1'b0;
        s_if.tdata  = b.data;
        s_if.tstrb  = b.strb;
        s_if.tuser  = b.user;
        s_if.tlast  = b.last;
        s_if.tvalid = 1'b1;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (s_if.tready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL s_tready_timeout: beat not accepted in 2000 cycles, required acceptance");
        end
    endtask

    task automatic send_pkt(input logic [7:0] id, input logic [7:0] src, input logic [15:0] etype,
                            input logic [3:0] ver, input logic [7:0] ttl, input logic [31:0] dip,
                            input int nbeats, input logic [7:0] exp_dst);
        beat_t b, e;
        for (int k = 0; k < nbeats; k++) begin
            b = mk_beat(id, k, src, etype, ver, ttl, dip, nbeats);
            e = b;
            if (k == 0) e.user[31:24] = exp_dst;
            exp_q.push_back(e);
            drive_beat(b);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        step(3);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s drain: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic tbl_write(input logic [4:0] a, input logic [31:0] d, input logic v);
        tbl_wr_req = 1'b1; tbl_wr_addr = a; tbl_wr_data = d; tbl_wr_entry_valid = v;
        step(1);
        tbl_wr_req = 1'b0;
        check("tbl_wr_ack", {31'b0, tbl_wr_ack}, 32'd1);
    endtask

    task automatic tbl_read(input string name, input logic [4:0] a, input logic [31:0] d, input logic v);
        tbl_rd_req = 1'b1; tbl_rd_addr = a;
        step(1);
        tbl_rd_req = 1'b0;
        check({name, " rd_ack"},   {31'b0, tbl_rd_ack}, 32'd1);
        check({name, " rd_data"},  tbl_rd_data, d);
        check({name, " rd_valid"}, {31'b0, tbl_rd_entry_valid}, {31'b0, v});
    endtask

    initial begin : stimulus
        beat_t b;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(1);
        check("reset m_tvalid", {31'b0, m_if.tvalid}, 32'd0);
        check("reset s_tready", {31'b0, s_if.tready}, 32'd1);
        check("reset acks", {30'b0, tbl_wr_ack, tbl_rd_ack}, 32'd0);
        check("reset rd_data", tbl_rd_data, 32'd0);
        check_cnt("reset", 0, 0, 0, 0, 0);

        // Router address hit from MAC0
        tbl_write(5'd3, 32'hC0A8_0101, 1'b1);
        tbl_read("entry3", 5'd3, 32'hC0A8_0101, 1'b1);
        send_pkt(8'h01, 8'h01, 16'h0800, 4'd4, 8'd64, 32'hC0A8_0101, 3, 8'h02);
        drain("hit");
        check_cnt("hit", 0, 0, 0, 1, 0);

        counter_clr = 1'b1; step(1); counter_clr = 1'b0;
        check_cnt("clear", 0, 0, 0, 0, 0);
        send_pkt(8'h02, 8'h01, 16'h0800, 4'd4, 8'd64, 32'h0A00_0001, 3, 8'h04);
        drain("miss");
        tbl_write(5'd3, 32'h0000_0000, 1'b0);
        send_pkt(8'h03, 8'h01, 16'h0800, 4'd4, 8'd64, 32'h0000_0000, 3, 8'h04);
        drain("invalid entry");
        check_cnt("miss", 0, 0, 0, 0, 0);

        // Non-IP, bad version/TTL, CPU origin, short packet
        send_pkt(8'h04, 8'h10, 16'h0806, 4'd4, 8'd0, 32'h0A00_0001, 2, 8'h20);
        drain("non_ip");
        check_cnt("non_ip", 0, 0, 1, 0, 0);
        send_pkt(8'h05, 8'h04, 16'h0800, 4'd6, 8'd1, 32'h0A00_0001, 3, 8'h08);
        drain("ver_ttl");
        check_cnt("ver_ttl", 1, 1, 1, 0, 0);
        send_pkt(8'h06, 8'h02, 16'h0800, 4'd4, 8'd0, 32'h0A00_0001, 2, 8'h01);
        drain("cpu");
        check_cnt("cpu", 1, 1, 1, 0, 0);
        send_pkt(8'h07, 8'h40, 16'h0800, 4'd4, 8'd0, 32'h0A00_0001, 1, 8'h80);
        drain("short");
        check_cnt("short", 1, 1, 1, 0, 1);

        // Output backpressure across three back-to-back packets
        m_if.tready = 1'b0;
        saw_full    = 1'b0;
        fork
            begin
                send_pkt(8'h10, 8'h01, 16'h0800, 4'd4, 8'd64, 32'h0A00_0001, 4, 8'h04);
                send_pkt(8'h11, 8'h01, 16'h0800, 4'd4, 8'd64, 32'h0A00_0002, 4, 8'h04);
                send_pkt(8'h12, 8'h01, 16'h0800, 4'd4, 8'd64, 32'h0A00_0003, 4, 8'h04);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (!s_if.tready) saw_full = 1'b1;
                end
                @(posedge clk);
                #1;
                m_if.tready = 1'b1;
            end
        join
        drain("backpressure");
        check("backpressure s_tready low", {31'b0, saw_full}, 32'd1);
        check_cnt("backpressure", 1, 1, 1, 0, 1);

        // Reset in the middle of a packet
        tbl_write(5'd3, 32'hC0A8_0101, 1'b1);
        m_if.tready = 1'b0;
        b = mk_beat(8'h20, 0, 8'h01, 16'h0800, 4'd4, 8'd64, 32'hC0A8_0101, 3);
        drive_beat(b);
        b = mk_beat(8'h20, 1, 8'h01, 16'h0800, 4'd4, 8'd64, 32'hC0A8_0101, 3);
        drive_beat(b);
        step(2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset m_tvalid", {31'b0, m_if.tvalid}, 32'd0);
        check_cnt("midreset", 0, 0, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        m_if.tready = 1'b1;
        step(1);
        check("postreset s_tready", {31'b0, s_if.tready}, 32'd1);
        tbl_read("postreset entry3", 5'd3, 32'h0, 1'b0);
        tbl_write(5'd3, 32'hC0A8_0101, 1'b1);
        send_pkt(8'h21, 8'h01, 16'h0800, 4'd4, 8'd64, 32'hC0A8_0101, 3, 8'h02);
        drain("postreset");
        check_cnt("postreset", 0, 0, 0, 1, 0);

        // Clear coincides with the hit decision; also checks first-beat latency
        fork
            send_pkt(8'h30, 8'h01, 16'h0800, 4'd4, 8'd64, 32'hC0A8_0101, 2, 8'h02);
            begin
                step(2);
                counter_clr = 1'b1;
                @(negedge clk);
                check("latency cycle2 m_tvalid", {31'b0, m_if.tvalid}, 32'd0);
                step(1);
                counter_clr = 1'b0;
                @(negedge clk);
                check("latency cycle3 m_tvalid", {31'b0, m_if.tvalid}, 32'd1);
            end
        join
        drain("clr_vs_hit");
        check_cnt("clr_vs_hit", 0, 0, 0, 0, 0);

        // Read and write of the same address in one cycle returns the old entry
        tbl_wr_req = 1'b1; tbl_wr_addr = 5'd5; tbl_wr_data = 32'hDEAD_BEEF; tbl_wr_entry_valid = 1'b1;
        tbl_rd_req = 1'b1; tbl_rd_addr = 5'd5;
        step(1);
        tbl_wr_req = 1'b0; tbl_rd_req = 1'b0;
        check("rd_during_wr data", tbl_rd_data, 32'h0);
        check("rd_during_wr valid", {31'b0, tbl_rd_entry_valid}, 32'd0);
        tbl_read("entry5", 5'd5, 32'hDEAD_BEEF, 1'b1);

        step(2);
        check("scoreboard empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
